// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: HD44780 4-bit bus driver. It runs the power-on nibble init,
// then accepts command/data bytes over valid/ready and sends each byte as two
// EN-strobed nibbles, followed by a timed execution wait. The busy flag is
// never read.
module lcd_byte_writer #(
    parameter int T_POWERUP    = 750000,
    parameter int T_INIT_WAIT  = 205000,
    parameter int T_SETUP      = 4,
    parameter int T_EN         = 24,
    parameter int T_NIBBLE_GAP = 50,
    parameter int T_CMD        = 2000,
    parameter int T_CLEAR      = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_rs,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       init_done,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic       d4,
    output logic       d5,
    output logic       d6,
    output logic       d7
);

    // The counter must hold the largest phase length minus one, and is never
    // narrower than 20 bits.
    localparam int M1   = (T_POWERUP > T_INIT_WAIT) ? T_POWERUP : T_INIT_WAIT;
    localparam int M2   = (M1 > T_CLEAR) ? M1 : T_CLEAR;
    localparam int M3   = (M2 > T_CMD) ? M2 : T_CMD;
    localparam int M4   = (M3 > T_NIBBLE_GAP) ? M3 : T_NIBBLE_GAP;
    localparam int M5   = (M4 > T_EN) ? M4 : T_EN;
    localparam int MAXP = (M5 > T_SETUP) ? M5 : T_SETUP;
    localparam int CW   = ($clog2(MAXP) > 20) ? $clog2(MAXP) : 20;

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_NIB,
        INIT_WAIT,
        IDLE,
        NIB_SETUP,
        NIB_EN,
        NIB_HOLD,
        GAP,
        EXEC_WAIT
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;       // init nibble index, 0..3
    logic          hi_q;        // current byte nibble is the high one
    logic [7:0]    byte_q;
    logic [3:0]    d_q;
    logic          rs_q;
    logic          en_q;
    logic          in_ready_q;
    logic          init_done_q;

    logic cnt_zero;
    logic is_clear;

    assign cnt_zero = (cnt_q == '0);
    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    assign is_clear = !rs_q && (byte_q[7:2] == 6'd0) && (byte_q[1:0] != 2'd0);

    // Single FSM: every phase loads N-1 on entry and leaves when the counter hits 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PWR_WAIT;
            cnt_q       <= CW'(T_POWERUP - 1);
            idx_q       <= 2'd0;
            hi_q        <= 1'b0;
            byte_q      <= 8'h00;
            d_q         <= 4'h0;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                PWR_WAIT: begin
                    if (cnt_zero) begin
                        state_q <= INIT_NIB;
                        cnt_q   <= CW'(T_SETUP - 1);
                        idx_q   <= 2'd0;
                        d_q     <= 4'h3;
                        rs_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                // Init nibbles and byte nibbles share the same setup phase timing.
                INIT_NIB, NIB_SETUP: begin
                    if (cnt_zero) begin
                        state_q <= NIB_EN;
                        cnt_q   <= CW'(T_EN - 1);
                        en_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                NIB_EN: begin
                    if (cnt_zero) begin
                        state_q <= NIB_HOLD;
                        cnt_q   <= CW'(T_SETUP - 1);
                        en_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                NIB_HOLD: begin
                    if (cnt_zero) begin
                        if (!init_done_q) begin
                            state_q <= INIT_WAIT;
                            cnt_q   <= (idx_q == 2'd3) ? CW'(T_CMD - 1) : CW'(T_INIT_WAIT - 1);
                        end else if (hi_q) begin
                            state_q <= GAP;
                            cnt_q   <= CW'(T_NIBBLE_GAP - 1);
                        end else begin
                            state_q <= EXEC_WAIT;
                            cnt_q   <= is_clear ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                INIT_WAIT: begin
                    if (cnt_zero) begin
                        if (idx_q == 2'd3) begin
                            state_q     <= IDLE;
                            init_done_q <= 1'b1;
                            in_ready_q  <= 1'b1;
                        end else begin
                            state_q <= INIT_NIB;
                            cnt_q   <= CW'(T_SETUP - 1);
                            idx_q   <= idx_q + 2'd1;
                            // Three 0x3 nibbles, then 0x2 switches to 4-bit mode.
                            d_q     <= (idx_q == 2'd2) ? 4'h2 : 4'h3;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= NIB_SETUP;
                        cnt_q      <= CW'(T_SETUP - 1);
                        byte_q     <= in_data;
                        rs_q       <= in_rs;
                        d_q        <= in_data[7:4];
                        hi_q       <= 1'b1;
                        in_ready_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (cnt_zero) begin
                        state_q <= NIB_SETUP;
                        cnt_q   <= CW'(T_SETUP - 1);
                        d_q     <= byte_q[3:0];
                        hi_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                EXEC_WAIT: begin
                    if (cnt_zero) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= PWR_WAIT;
                    cnt_q   <= CW'(T_POWERUP - 1);
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign init_done = init_done_q;
    assign rs        = rs_q;
    assign rw        = 1'b0;
    assign en        = en_q;
    assign d4        = d_q[0];
    assign d5        = d_q[1];
    assign d6        = d_q[2];
    assign d7        = d_q[3];

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Bench for lcd_byte_writer: directed and random bytes, checked against a
// timeline model of the expected EN pulses and handshake latencies.
module tb_lcd_byte_writer;

    localparam int TPU = 100, TIW = 40, TS = 2, TEN = 3, TG = 5, TCMD = 10, TCLR = 30;
    localparam int PULSE   = 2 * TS + TEN;
    localparam int INIT_CY = TPU + 4 * PULSE + 3 * TIW + TCMD;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_rs, in_valid;
    logic       in_ready, init_done, rs, rw, en, d4, d5, d6, d7;

    lcd_byte_writer #(
        .T_POWERUP(TPU), .T_INIT_WAIT(TIW), .T_SETUP(TS), .T_EN(TEN),
        .T_NIBBLE_GAP(TG), .T_CMD(TCMD), .T_CLEAR(TCLR)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_rs(in_rs), .in_valid(in_valid),
        .in_ready(in_ready), .init_done(init_done), .rs(rs), .rw(rw), .en(en),
        .d4(d4), .d5(d5), .d6(d6), .d7(d7)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [3:0] d;
        int         w;
        int         rise;
    } pulse_t;

    pulse_t pq[$];
    int cyc = 0;
    int errors = 0, checks = 0;
    int rw_bad = 0, stab_bad = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Pin monitor: records every completed EN pulse with its nibble, rs, width and rise cycle.
    initial begin
        logic   en_prev;
        pulse_t cur;
        en_prev = 1'b0;
        cur = '{rs: 1'b0, d: 4'h0, w: 0, rise: 0};
        forever begin
            @(negedge clk);
            if (rw !== 1'b0) rw_bad++;
            if (rst) begin
                en_prev = 1'b0;
            end else begin
                if (en && !en_prev) begin
                    cur.rs = rs; cur.d = {d7, d6, d5, d4}; cur.w = 0; cur.rise = cyc;
                end
                if (en) begin
                    cur.w++;
                    if ({d7, d6, d5, d4} !== cur.d || rs !== cur.rs) stab_bad++;
                end
                if (!en && en_prev) pq.push_back(cur);
                en_prev = en;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exec_cy(input logic [7:0] b, input logic r);
        return (!r && b >= 8'h01 && b <= 8'h03) ? TCLR : TCMD;
    endfunction

    function automatic int byte_cy(input logic [7:0] b, input logic r);
        return 2 * PULSE + TG + exec_cy(b, r);
    endfunction

    // Waits (bounded) at negedges until in_ready is high.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (in_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Releases reset and checks the init timing and the four init nibbles.
    task automatic do_init();
        int e0, lat;
        logic [3:0] exp_n[4];
        pulse_t p;
        exp_n[0] = 4'h3; exp_n[1] = 4'h3; exp_n[2] = 4'h3; exp_n[3] = 4'h2;
        e0 = cyc;
        pq.delete();
        rst = 1'b0;
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            if (init_done === 1'b1) begin lat = cyc - e0; break; end
            @(negedge clk);
        end
        check("init_done_cycle", lat, INIT_CY);
        check("init_ready", {31'd0, in_ready}, 32'd1);
        check("init_pulse_count", pq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (pq.size() > 0) begin
                p = pq.pop_front();
                check($sformatf("init_nib%0d", i), {23'd0, p.rs, p.d, 4'(p.w)}, {23'd0, 1'b0, exp_n[i], 4'(TEN)});
            end
        end
    endtask

    // Sends one byte in the first in_ready cycle, scrambles inputs right after
    // the accept edge and toggles in_valid during the busy period.
    task automatic send(input logic [7:0] b, input logic r);
        int a, lat;
        bit ok;
        pulse_t p;
        pq.delete();
        wait_ready(ok);
        if (!ok) return;
        in_valid = 1'b1; in_data = b; in_rs = r;
        @(negedge clk);
        a = cyc;
        in_valid = 1'b0; in_data = 8'($urandom); in_rs = 1'($urandom);
        lat = -1;
        for (int i = 0; i < 500; i++) begin
            if (in_ready === 1'b1) begin in_valid = 1'b0; lat = cyc - a; break; end
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check($sformatf("latency_%02h_%0d", b, r), lat, byte_cy(b, r));
        check($sformatf("pulses_%02h", b), pq.size(), 2);
        if (pq.size() >= 2) begin
            p = pq.pop_front();
            check($sformatf("hi_%02h", b), {15'd0, p.rs, p.d, 4'(p.w), 8'(p.rise - a)},
                  {15'd0, r, b[7:4], 4'(TEN), 8'(TS)});
            p = pq.pop_front();
            check($sformatf("lo_%02h", b), {15'd0, p.rs, p.d, 4'(p.w), 8'(p.rise - a)},
                  {15'd0, r, b[3:0], 4'(TEN), 8'(3 * TS + TEN + TG)});
        end
    endtask

    initial begin
        logic [7:0] bb[3];
        logic [3:0] exp_seq[6];
        int acc[3];
        bit ok;
        pulse_t p;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_rs = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pins", {23'd0, rs, rw, en, d7, d6, d5, d4, in_ready, init_done}, 32'd0);

        do_init();

        send(8'h48, 1'b1);
        send(8'h01, 1'b0);
        send(8'h00, 1'b0);
        send(8'h02, 1'b0);
        for (int i = 0; i < 8; i++) send(8'($urandom), 1'($urandom));

        // Back-to-back with in_valid held high.
        bb[0] = 8'h28; bb[1] = 8'h0C; bb[2] = 8'h06;
        pq.delete();
        wait_ready(ok);
        in_rs = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = bb[i];
            for (int k = 0; k < 200; k++) begin
                if (in_ready === 1'b1) break;
                @(negedge clk);
            end
            @(negedge clk);
            acc[i] = cyc;
        end
        in_valid = 1'b0;
        wait_ready(ok);
        check("b2b_spacing0", acc[1] - acc[0], byte_cy(bb[0], 1'b0) + 1);
        check("b2b_spacing1", acc[2] - acc[1], byte_cy(bb[1], 1'b0) + 1);
        check("b2b_pulse_count", pq.size(), 6);
        for (int i = 0; i < 3; i++) begin
            exp_seq[2 * i] = bb[i][7:4];
            exp_seq[2 * i + 1] = bb[i][3:0];
        end
        for (int i = 0; i < 6; i++) begin
            if (pq.size() > 0) begin
                p = pq.pop_front();
                check($sformatf("b2b_nib%0d", i), {27'd0, p.rs, p.d}, {27'd0, 1'b0, exp_seq[i]});
            end
        end

        // Reset while en is high during a byte.
        wait_ready(ok);
        in_valid = 1'b1; in_data = 8'hA5; in_rs = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (en === 1'b1) break;
            @(negedge clk);
        end
        check("en_high_before_rst", {31'd0, en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pins", {23'd0, rs, rw, en, d7, d6, d5, d4, in_ready, init_done}, 32'd0);
        @(negedge clk);
        do_init();
        send(8'h3C, 1'b1);

        check("rw_low_always", rw_bad, 0);
        check("pins_stable_in_pulse", stab_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
